// File: rtl/pair_scan_ctrl.sv
// Word-to-bit-serial sequencer around a non-overlapping two-equal-bit Mealy pair detector.
// Latency: word accepted at edge E0, result (out_valid) presented after edge E0+WIDTH.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no input queueing.
module pair_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             bit_valid,
  output logic             bit_match,
  output logic [IDX_W-1:0] bit_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic [IDX_W-1:0] first_idx,
  output logic             any_match,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
  typedef enum logic [1:0] {D_START, D_ZERO, D_ONE} det_t;

  state_t           r_state, w_state_nxt;
  det_t             r_det, w_det_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [IDX_W-1:0] r_idx;
  logic             r_bit_valid, r_bit_match;
  logic [IDX_W-1:0] r_bit_idx, r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             r_any;
  logic             w_bit, w_match, w_accept, w_last;

  assign w_bit    = r_shift[0];
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_idx == IDX_W'(WIDTH - 1));

  // Next-state for the sequencer and the pair detector; detector output is the Mealy match.
  always_comb begin
    w_state_nxt = r_state;
    w_det_nxt   = r_det;
    w_match     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SCAN;
          w_det_nxt   = D_START;
        end
      end
      S_SCAN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_det_nxt   = D_START;
        end else begin
          w_match = ((r_det == D_ONE) && w_bit) || ((r_det == D_ZERO) && !w_bit);
          // A completed pair restarts pairing from the next bit.
          if (w_match)    w_det_nxt = D_START;
          else if (w_bit) w_det_nxt = D_ONE;
          else            w_det_nxt = D_ZERO;
          if (w_last) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_det_nxt   = D_START;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_det   <= D_START;
    end else begin
      r_state <= w_state_nxt;
      r_det   <= w_det_nxt;
    end
  end

  // Word capture, bit shifting, per-bit report and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_bit_valid <= 1'b0;
      r_bit_match <= 1'b0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
      r_any       <= 1'b0;
    end else begin
      r_bit_valid <= 1'b0;
      r_bit_match <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift <= in_data;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_cnt   <= '0;
            r_first <= '0;
            r_any   <= 1'b0;
          end else begin
            r_shift     <= r_shift >> 1;
            r_idx       <= r_idx + IDX_W'(1);
            r_bit_valid <= 1'b1;
            r_bit_match <= w_match;
            r_bit_idx   <= r_idx;
            if (w_match) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (!r_any) begin
                r_first <= r_idx;
                r_any   <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign bit_valid = r_bit_valid;
  assign bit_match = r_bit_match;
  assign bit_idx   = r_bit_idx;
  assign match_cnt = r_cnt;
  assign first_idx = r_first;
  assign any_match = r_any;

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Randomized self-checking bench for pair_scan_ctrl against a word-level pairing model.
// Latency: checks per-bit reports one edge after each consumed bit, result after WIDTH edges.
// Backpressure: holds out_ready low for random spells while driving ignored in_valid.
module tb_pair_scan_ctrl;
  localparam int WIDTH = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, abort;
  logic [WIDTH-1:0] in_data;
  logic             bit_valid, bit_match, out_valid, out_ready, any_match, busy;
  logic [IDX_W-1:0] bit_idx, first_idx;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pair_scan_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .abort(abort), .bit_valid(bit_valid), .bit_match(bit_match), .bit_idx(bit_idx),
    .out_valid(out_valid), .out_ready(out_ready), .match_cnt(match_cnt),
    .first_idx(first_idx), .any_match(any_match), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pairs bits greedily from the LSB: a bit either closes an open pair of equal value
  // (match, pair consumed) or opens a new candidate.
  function automatic logic [WIDTH-1:0] ref_mask(input logic [WIDTH-1:0] w);
    logic have, prev;
    logic [WIDTH-1:0] m;
    have = 1'b0; prev = 1'b0; m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (have && (w[i] == prev)) begin
        m[i] = 1'b1;
        have = 1'b0;
      end else begin
        prev = w[i];
        have = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_bit_valid"}, bit_valid, 0);
  endtask

  task automatic accept(input logic [WIDTH-1:0] w);
    @(negedge clk);
    check("pre_accept_in_ready", in_ready, 1);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    check("scan_busy", busy, 1);
    check("scan_in_ready", in_ready, 0);
    check("scan_first_bit_valid", bit_valid, 0);
  endtask

  task automatic run_scan(input logic [WIDTH-1:0] w, input int hold);
    logic [WIDTH-1:0] m;
    int cnt, first;
    m = ref_mask(w);
    cnt = $countones(m);
    first = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (m[i]) first = i;
    accept(w);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      check("bit_valid", bit_valid, 1);
      check("bit_idx", bit_idx, i);
      check("bit_match", bit_match, m[i]);
      check("out_valid_timing", out_valid, (i == WIDTH - 1) ? 1 : 0);
    end
    check("match_cnt", match_cnt, cnt);
    check("first_idx", first_idx, first);
    check("any_match", any_match, (cnt != 0) ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_bit_valid", bit_valid, 0);
      check("hold_match_cnt", match_cnt, cnt);
      check("hold_first_idx", first_idx, first);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check_idle_outputs("handoff");
  endtask

  task automatic run_abort(input logic [WIDTH-1:0] w, input int at);
    logic [WIDTH-1:0] m;
    m = ref_mask(w);
    accept(w);
    for (int i = 0; i < at; i++) begin
      @(negedge clk);
      check("pre_abort_bit_idx", bit_idx, i);
      check("pre_abort_bit_match", bit_match, m[i]);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("abort");
    check("abort_match_cnt", match_cnt, 0);
    check("abort_any_match", any_match, 0);
    repeat (2) begin
      @(negedge clk);
      check("post_abort_out_valid", out_valid, 0);
    end
  endtask

  task automatic run_reset(input logic [WIDTH-1:0] w, input int at);
    accept(w);
    repeat (at) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_match_cnt", match_cnt, 0);
    check("midrst_first_idx", first_idx, 0);
    check("midrst_any_match", any_match, 0);
    check("midrst_bit_idx", bit_idx, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    check_idle_outputs("reset");
    check("reset_match_cnt", match_cnt, 0);
    check("reset_first_idx", first_idx, 0);
    check("reset_any_match", any_match, 0);
    check("reset_bit_match", bit_match, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_scan(16'b0101011101110010, 0);
    run_scan(16'h0000, 0);
    run_scan(16'hFFFF, 0);
    run_scan(16'h5555, 0);
    run_scan(16'hA5C3, 5);
    run_abort(16'h0000, 7);
    run_scan(16'h0003, 0);
    run_abort(16'h0001, 1);
    run_scan(16'h0002, 0);
    run_reset(16'h0000, 5);
    run_scan(16'h0F0F, 1);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) run_abort(w, $urandom_range(0, WIDTH - 1));
      else run_scan(w, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pair_scan_ctrl.md
Name: pair_scan_ctrl

Overview:
Sequencing controller for the two-consecutive-equal-bit Mealy detector. Accepts a parallel word over a valid/ready handshake and feeds it bit-serially, LSB first, through an embedded pair-detector stage, one bit per clk. Returns match count, first-match index and a per-bit match stream. Sits between a word-oriented producer and consumer so the bit-serial detector can be used without hand-driven stimulus.

Parameters:
WIDTH, 16, bits per scanned word (>=2)
IDX_W, 4, bit-index width; 2^IDX_W >= WIDTH
CNT_W, 5, match-count width; 2^CNT_W > WIDTH/2

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  producer has a word
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  word to scan, bit 0 first
abort  input  1  synchronous scan cancel
bit_valid  output  1  bit_match/bit_idx valid this cycle
bit_match  output  1  registered detector output for bit bit_idx
bit_idx  output  IDX_W  index of bit just processed
out_valid  output  1  result available
out_ready  input  1  consumer takes result
match_cnt  output  CNT_W  number of matches in word
first_idx  output  IDX_W  index of first matching bit
any_match  output  1  match_cnt != 0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, detector state START, all outputs 0 except in_ready=1; shift register, counters cleared.
- Detector stage, per processed bit b (states START, ZERO, ONE):
  - START: b=1 -> ONE, b=0 -> ZERO, no match.
  - ONE: b=1 -> START with match; b=0 -> ZERO.
  - ZERO: b=0 -> START with match; b=1 -> ONE.
  - Pairs are non-overlapping: after a match the next bit starts fresh, so "111" matches only at index 1.
  - Detector state forced to START at every word acceptance.
- FSM IDLE:
  - in_ready=1; accept on in_valid && in_ready.
  - Acceptance latches in_data, clears match_cnt/first_idx/any_match, sets idx=0, goes to SCAN.
- FSM SCAN:
  - in_ready=0; each cycle processes bit idx.
  - At that edge: bit_valid=1, bit_idx=idx, bit_match=detector match (registered, visible the cycle after the bit is consumed).
  - On match: match_cnt+1; if it is the first match, first_idx=idx and any_match=1.
  - After bit WIDTH-1 -> DONE.
  - Exactly WIDTH SCAN cycles per word.
  - bit_valid is 0 outside these WIDTH pulses.
- FSM DONE:
  - out_valid=1; match_cnt/first_idx/any_match held stable until out_valid && out_ready, then IDLE the next edge.
  - in_ready stays 0 in DONE; no new word is accepted in the handoff cycle.
- Latency: acceptance at edge E0 -> out_valid high after edge E0+WIDTH. Minimum word-to-word period is WIDTH+2 cycles with out_ready tied high.
- No match: first_idx=0, any_match=0, match_cnt=0.
- abort:
  - In SCAN: return to IDLE next edge, no out_valid, bit_valid=0 from that edge, results cleared.
  - Ignored in IDLE and DONE.
  - abort has priority over completion on the last bit.
- Reset mid-SCAN or mid-DONE: immediate IDLE, pending result discarded, out_valid drops asynchronously.
- in_data changes after acceptance have no effect. in_valid while busy is ignored and is not queued.

Test Plan:
- Reset then in_data=16'b0101011101110010 accepted -> bit_match high at bit_idx 3, 5, 9 only; out_valid 16 cycles after accept; match_cnt=3, first_idx=3, any_match=1.
- in_data=16'h0000, then 16'hFFFF -> each gives matches at odd indices 1..15; match_cnt=8, first_idx=1.
- in_data=16'h5555 -> no bit_match pulses; match_cnt=0, first_idx=0, any_match=0.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, then the next word is accepted.
- abort at bit_idx=7 during a scan of 16'h0000 -> no out_valid; busy=0 next edge; a following scan of 16'h0003 gives match_cnt=1 with first_idx=1, proving detector state was cleared.
- rst asserted mid-SCAN -> all outputs at reset values immediately, in_ready=1; the next word scans correctly.
